// File: rtl/local_bht_update_ctrl.sv
// Read-modify-write updater for the local BHT pattern array: FIFO of resolved branches, then READ/WRITE per entry.
// Optional committed-update counter enabled by defining LOCAL_BHT_UPD_CNT_EN.
module local_bht_update_ctrl #(
    parameter int width = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             upd_valid_i,
    input  logic [5:0]       upd_index_i,
    input  logic             upd_taken_i,
    output logic             upd_ready_o,
    output logic [5:0]       arr_index_in_o,
    input  logic [width-1:0] arr_dataout_i,
    output logic             arr_write_o,
    output logic [width-1:0] arr_datain_o,
    output logic             busy_o,
    output logic [15:0]      upd_count_o
);

    // state   | meaning
    // S_IDLE  | FIFO empty, array port parked at index 0
    // S_READ  | head index presented, shifted pattern captured at end of cycle
    // S_WRITE | arr_write high, head popped at end of cycle
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_e             state_q, state_d;
    logic [PW-1:0]      head_q, tail_q;
    logic [CW-1:0]      count_q;
    logic [width-1:0]   hold_q;
    logic [5:0]         fifo_idx_q [DEPTH];
    logic               fifo_tk_q  [DEPTH];

    logic               full;
    logic               accept;
    logic               pop;
    logic [5:0]         head_idx;
    logic               head_tk;
    logic               unused_dataout_msb;

    assign full        = (count_q == CW'(DEPTH));
    // Held low through reset so the source never sees a ready it cannot use.
    assign upd_ready_o = !rst_i && !full;
    assign accept      = upd_valid_i && upd_ready_o;
    assign pop         = (state_q == S_WRITE);
    assign head_idx    = fifo_idx_q[head_q];
    assign head_tk     = fifo_tk_q[head_q];

    // The MSB of the old pattern is shifted out and never stored.
    assign unused_dataout_msb = arr_dataout_i[width-1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if ((count_q != '0) || accept) state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = ((count_q > CW'(1)) || accept) ? S_READ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pop)    head_q <= head_q + PW'(1);
            if (accept) tail_q <= tail_q + PW'(1);
            case ({accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (state_q == S_READ) hold_q <= {arr_dataout_i[width-2:0], head_tk};
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_idx_q[tail_q] <= upd_index_i;
            fifo_tk_q[tail_q]  <= upd_taken_i;
        end
    end

    assign arr_write_o    = (state_q == S_WRITE);
    assign arr_index_in_o = (state_q == S_IDLE) ? 6'd0 : head_idx;
    assign arr_datain_o   = hold_q;
    assign busy_o         = (count_q != '0) || (state_q != S_IDLE);

`ifdef LOCAL_BHT_UPD_CNT_EN
    logic [15:0] upd_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            upd_cnt_q <= '0;
        end else if (pop && (upd_cnt_q != 16'hFFFF)) begin
            upd_cnt_q <= upd_cnt_q + 16'd1;
        end
    end

    assign upd_count_o = upd_cnt_q;
`else
    assign upd_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_local_bht_update_ctrl.sv
// Randomized bench for local_bht_update_ctrl: a schedule-based model predicts every array write and port value.
module tb_local_bht_update_ctrl;
    localparam int W    = 128;
    localparam int D    = 4;
    localparam int MAXE = 512;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         upd_valid = 1'b0;
    logic [5:0]   upd_index = '0;
    logic         upd_taken = 1'b0;
    logic         upd_ready;
    logic [5:0]   arr_index_in;
    logic [W-1:0] arr_dataout;
    logic         arr_write;
    logic [W-1:0] arr_datain;
    logic         busy;
    logic [15:0]  upd_count;

    local_bht_update_ctrl #(.width(W), .DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst), .upd_valid_i(upd_valid), .upd_index_i(upd_index),
        .upd_taken_i(upd_taken), .upd_ready_o(upd_ready), .arr_index_in_o(arr_index_in),
        .arr_dataout_i(arr_dataout), .arr_write_o(arr_write), .arr_datain_o(arr_datain),
        .busy_o(busy), .upd_count_o(upd_count)
    );

    always #5 clk = ~clk;

`ifdef LOCAL_BHT_UPD_CNT_EN
    localparam logic [15:0] CNT_AFTER3 = 16'd3;
`else
    localparam logic [15:0] CNT_AFTER3 = 16'd0;
`endif

    // Pattern array: combinational read, write on the falling edge.
    logic [W-1:0] arr_mem [64];
    logic         preset_go = 1'b0;
    logic [5:0]   preset_idx = '0;
    logic [W-1:0] preset_val = '0;

    assign arr_dataout = arr_mem[arr_index_in];

    always @(negedge clk) begin
        if (arr_write)      arr_mem[arr_index_in] <= arr_datain;
        else if (preset_go) arr_mem[preset_idx]   <= preset_val;
    end

    // Model: entry k is accepted into cycle e_acc and written in cycle
    // e_wr = max(e_acc+1, previous e_wr+2); expected data comes from a
    // reference array updated in acceptance order.
    int           cyc = 0;
    int           n_ent = 0;
    int           e_acc [MAXE];
    int           e_wr  [MAXE];
    logic [5:0]   e_idx [MAXE];
    logic [W-1:0] e_val [MAXE];
    logic [W-1:0] e_prev[MAXE];
    logic [W-1:0] ref_mem [64];
    logic         last_acc = 1'b0;
    int           n_cmp = 0;
    int           n_err = 0;
    int           m_c, m_w, m_r, m_commit, m_wr;

    logic         pin_go = 1'b0;
    string        pin_name = "";
    logic [W-1:0] pin_got = '0;
    logic [W-1:0] pin_exp = '0;

    function automatic int m_cnt(input int t);
        int c = 0;
        for (int i = 0; i < n_ent; i++)
            if (e_acc[i] <= t && e_wr[i] >= t) c++;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pin_go) chk(pin_name, pin_got, pin_exp);
        if (rst) begin
            chk("rst_ready", W'(upd_ready), '0);
            chk("rst_write", W'(arr_write), '0);
            chk("rst_index", W'(arr_index_in), '0);
            chk("rst_datain", arr_datain, '0);
            chk("rst_busy", W'(busy), '0);
            chk("rst_count", W'(upd_count), '0);
            for (int i = n_ent - 1; i >= 0; i--)
                if (e_wr[i] >= cyc) ref_mem[e_idx[i]] = e_prev[i];
            n_ent    = 0;
            last_acc = 1'b0;
        end else begin
            m_c = m_cnt(cyc);
            m_w = -1;
            m_r = -1;
            m_commit = 0;
            for (int i = 0; i < n_ent; i++) begin
                if (e_wr[i] == cyc) m_w = i;
                if (e_wr[i] == cyc + 1 && e_acc[i] <= cyc) m_r = i;
                if (e_wr[i] < cyc) m_commit++;
            end
            chk("ready", W'(upd_ready), W'(m_c < D));
            chk("busy", W'(busy), W'(m_c > 0));
            chk("write", W'(arr_write), W'(m_w >= 0));
            if (m_w >= 0) begin
                chk("index_w", W'(arr_index_in), W'(e_idx[m_w]));
                chk("datain", arr_datain, e_val[m_w]);
            end else if (m_r >= 0) begin
                chk("index_r", W'(arr_index_in), W'(e_idx[m_r]));
            end else begin
                chk("index_idle", W'(arr_index_in), '0);
            end
`ifdef LOCAL_BHT_UPD_CNT_EN
            chk("count", W'(upd_count), W'((m_commit > 65535) ? 65535 : m_commit));
`else
            chk("count", W'(upd_count), '0);
`endif
            last_acc = upd_valid && (m_c < D) && (n_ent < MAXE);
            if (last_acc) begin
                m_wr = cyc + 2;
                if (n_ent > 0 && e_wr[n_ent-1] + 2 > m_wr) m_wr = e_wr[n_ent-1] + 2;
                e_acc[n_ent]  = cyc + 1;
                e_wr[n_ent]   = m_wr;
                e_idx[n_ent]  = upd_index;
                e_prev[n_ent] = ref_mem[upd_index];
                ref_mem[upd_index] = {ref_mem[upd_index][W-2:0], upd_taken};
                e_val[n_ent]  = ref_mem[upd_index];
                n_ent++;
            end
        end
        if (preset_go) ref_mem[preset_idx] = preset_val;
        cyc++;
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pin(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        pin_name = nm;
        pin_got  = got;
        pin_exp  = exp;
        pin_go   = 1'b1;
        tick(1);
        pin_go   = 1'b0;
    endtask

    task automatic preset(input logic [5:0] idx, input logic [W-1:0] val);
        preset_idx = idx;
        preset_val = val;
        preset_go  = 1'b1;
        tick(1);
        preset_go  = 1'b0;
    endtask

    task automatic push(input logic [5:0] idx, input logic tk);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_taken = tk;
        for (int k = 0; k < 64; k++) begin
            tick(1);
            if (last_acc) return;
        end
        upd_valid = 1'b0;
        pin("push_timeout", '0, W'(1));
    endtask

    initial begin
        tick(1);
        for (int i = 0; i < 64; i++)
            preset(6'(i), {$urandom, $urandom, $urandom, $urandom});
        tick(2);
        rst = 1'b0;
        tick(2);

        preset(6'd5, '0);
        push(6'd5, 1'b1);
        upd_valid = 1'b0;
        tick(6);
        pin("t1_arr5", arr_mem[5], W'(1));

        preset(6'd9, '0);
        push(6'd9, 1'b1);
        push(6'd9, 1'b0);
        upd_valid = 1'b0;
        tick(8);
        pin("t2_arr9", arr_mem[9], W'(2));
        pin("count_after3", W'(upd_count), W'(CNT_AFTER3));

        for (int i = 0; i < 6; i++) preset(6'(i), '0);
        for (int i = 0; i < 6; i++) push(6'(i), 1'b1);
        upd_valid = 1'b0;
        tick(20);
        for (int i = 0; i < 6; i++) pin("t3_arr", arr_mem[i], W'(1));

        preset(6'd20, W'(5));
        preset(6'd21, '0);
        preset(6'd22, '0);
        push(6'd20, 1'b0);
        push(6'd21, 1'b1);
        push(6'd22, 1'b1);
        upd_valid = 1'b0;
        tick(10);
        pin("t4_arr20", arr_mem[20], W'(10));
        pin("t4_arr21", arr_mem[21], W'(1));
        pin("t4_arr22", arr_mem[22], W'(1));

        preset(6'd40, '0);
        preset(6'd41, W'(1));
        preset(6'd7, W'(3));
        push(6'd40, 1'b1);
        push(6'd7, 1'b1);
        push(6'd41, 1'b0);
        // Now in the READ cycle of index 7 with index 41 still queued.
        rst = 1'b1;
        upd_valid = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(8);
        pin("rst_arr7", arr_mem[7], W'(3));
        pin("rst_arr41", arr_mem[41], W'(1));
        pin("rst_arr40", arr_mem[40], W'(1));

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) push(6'($urandom_range(0, 3)), 1'($urandom));
            else push(6'($urandom_range(0, 63)), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                upd_valid = 1'b0;
                tick($urandom_range(1, 4));
            end
        end
        upd_valid = 1'b0;
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
